// File: rtl/serial_frame_deserializer_if.sv
// Serial line and parallel word bundle between a frame source and the deserializer.
// master drives the line and strobe; slave returns the assembled word and status.
interface serial_frame_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             serial_in;
    logic             bit_en;
    logic [WIDTH-1:0] Data_out;
    logic             data_valid;
    logic             frame_error;
    logic             busy;

    modport master (
        output serial_in,
        output bit_en,
        input  Data_out,
        input  data_valid,
        input  frame_error,
        input  busy
    );

    modport slave (
        input  serial_in,
        input  bit_en,
        output Data_out,
        output data_valid,
        output frame_error,
        output busy
    );
endinterface

// File: rtl/serial_frame_deserializer.sv
// Receives start / WIDTH data / stop frames sampled on bit_en and presents each
// correctly framed word with a one-cycle data_valid load pulse.
//
//   state | meaning
//   IDLE  | line idle, waiting for a low sample (start bit)
//   DATA  | shifting in data bits, cnt_q = index of the bit being sampled
//   STOP  | next strobe samples the stop bit: high loads Data_out, low flags error
module serial_frame_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input logic                   clock,
    input logic                   reset_n,
    serial_frame_deserializer_if.slave bus
);
    localparam int              CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state,   state_nxt;
    logic [WIDTH-1:0] shift_q, shift_nxt;
    logic [WIDTH-1:0] data_q,  data_nxt;
    logic [CW-1:0]    cnt_q,   cnt_nxt;
    logic             valid_q, valid_nxt;
    logic             err_q,   err_nxt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            shift_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift_q <= shift_nxt;
            data_q  <= data_nxt;
            cnt_q   <= cnt_nxt;
            valid_q <= valid_nxt;
            err_q   <= err_nxt;
        end
    end

    // serial_in is only looked at under bit_en, so an undriven line between strobes is harmless
    always_comb begin
        state_nxt = state;
        shift_nxt = shift_q;
        data_nxt  = data_q;
        cnt_nxt   = cnt_q;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        if (bus.bit_en) begin
            unique case (state)
                IDLE: begin
                    if (!bus.serial_in) begin
                        state_nxt = DATA;
                        cnt_nxt   = '0;
                    end
                end
                DATA: begin
                    if (MSB_FIRST)
                        shift_nxt = {shift_q[WIDTH-2:0], bus.serial_in};
                    else
                        shift_nxt = {bus.serial_in, shift_q[WIDTH-1:1]};
                    if (cnt_q == LAST)
                        state_nxt = STOP;
                    else
                        cnt_nxt = cnt_q + CW'(1);
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (bus.serial_in) begin
                        data_nxt  = shift_q;
                        valid_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.Data_out    = data_q;
    assign bus.data_valid  = valid_q;
    assign bus.frame_error = err_q;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed bench: one LSB-first and one MSB-first deserializer share the same serial line,
// with a model of the downstream enable-loaded register fed from the LSB-first instance.
module tb_serial_frame_deserializer;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic line    = 1'b1;
    logic ben     = 1'b0;
    int   errors  = 0;
    int   checks  = 0;
    logic [7:0] reg_q;
    logic [7:0] exp_reg = 8'h00;

    always #5 clock = ~clock;

    serial_frame_deserializer_if #(.WIDTH(8)) if0 ();
    serial_frame_deserializer_if #(.WIDTH(8)) if1 ();

    assign if0.serial_in = line;
    assign if0.bit_en    = ben;
    assign if1.serial_in = line;
    assign if1.bit_en    = ben;

    serial_frame_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (if0.slave)
    );

    serial_frame_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (if1.slave)
    );

    // downstream 8-bit register: en = data_valid, Data_in = Data_out
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            reg_q <= 8'h00;
        else if (if0.data_valid)
            reg_q <= if0.Data_out;
    end

    typedef struct {
        logic [7:0] val;
        logic       stop;
        int         gap;
        int         post;
        logic       exp_dv;
        logic       exp_fe;
        logic [7:0] exp_lsb;
        logic [7:0] exp_msb;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            ben  = 1'b0;
            line = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
        end
    endtask

    task automatic strobe(input logic b);
        line = b;
        ben  = 1'b1;
        @(posedge clock);
        #1;
        ben  = 1'b0;
        line = 1'($urandom_range(0, 1));
    endtask

    task automatic send_start(input int gap, input string name);
        strobe(1'b0);
        chk({name, " busy after start"}, 32'(if0.busy), 32'd1);
        chk({name, " busy_msb after start"}, 32'(if1.busy), 32'd1);
        chk({name, " dv after start"}, 32'(if0.data_valid), 32'd0);
        idle(gap - 1);
    endtask

    task automatic send_bits(input logic [7:0] val, input int from, input int to, input int gap);
        for (int i = from; i <= to; i++) begin
            strobe(val[i]);
            idle(gap - 1);
        end
    endtask

    task automatic stop_check(input logic stop, input logic edv, input logic efe,
                              input logic [7:0] e0, input logic [7:0] e1, input string name);
        chk({name, " busy before stop"}, 32'(if0.busy), 32'd1);
        strobe(stop);
        chk({name, " data_valid"}, 32'(if0.data_valid), 32'(edv));
        chk({name, " frame_error"}, 32'(if0.frame_error), 32'(efe));
        chk({name, " Data_out lsb"}, 32'(if0.Data_out), 32'(e0));
        chk({name, " data_valid msb"}, 32'(if1.data_valid), 32'(edv));
        chk({name, " Data_out msb"}, 32'(if1.Data_out), 32'(e1));
        chk({name, " busy after stop"}, 32'(if0.busy), 32'd0);
        if (edv) exp_reg = e0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{val: 8'h18, stop: 1'b1, gap: 4, post: 0, exp_dv: 1'b1, exp_fe: 1'b0, exp_lsb: 8'h18, exp_msb: 8'h18};
        vecs[1] = '{val: 8'h81, stop: 1'b1, gap: 4, post: 3, exp_dv: 1'b1, exp_fe: 1'b0, exp_lsb: 8'h81, exp_msb: 8'h81};
        vecs[2] = '{val: 8'hA5, stop: 1'b0, gap: 4, post: 2, exp_dv: 1'b0, exp_fe: 1'b1, exp_lsb: 8'h81, exp_msb: 8'h81};
        vecs[3] = '{val: 8'h3C, stop: 1'b1, gap: 3, post: 2, exp_dv: 1'b1, exp_fe: 1'b0, exp_lsb: 8'h3C, exp_msb: 8'h3C};
        vecs[4] = '{val: 8'h55, stop: 1'b1, gap: 1, post: 0, exp_dv: 1'b1, exp_fe: 1'b0, exp_lsb: 8'h55, exp_msb: 8'hAA};
        vecs[5] = '{val: 8'h01, stop: 1'b1, gap: 1, post: 2, exp_dv: 1'b1, exp_fe: 1'b0, exp_lsb: 8'h01, exp_msb: 8'h80};

        // reset with random activity on the inputs
        for (int i = 0; i < 8; i++) begin
            line = 1'($urandom_range(0, 1));
            ben  = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
        end
        chk("reset Data_out", 32'(if0.Data_out), 32'h00);
        chk("reset data_valid", 32'(if0.data_valid), 32'd0);
        chk("reset frame_error", 32'(if0.frame_error), 32'd0);
        chk("reset busy", 32'(if0.busy), 32'd0);
        chk("reset busy msb", 32'(if1.busy), 32'd0);
        ben  = 1'b0;
        line = 1'b1;
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1;

        // idle-high samples must not start a frame
        strobe(1'b1);
        strobe(1'b1);
        chk("idle high busy", 32'(if0.busy), 32'd0);

        for (int v = 0; v < 6; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            send_start(vecs[v].gap, nm);
            send_bits(vecs[v].val, 0, 7, vecs[v].gap);
            stop_check(vecs[v].stop, vecs[v].exp_dv, vecs[v].exp_fe,
                       vecs[v].exp_lsb, vecs[v].exp_msb, nm);
            if (vecs[v].post > 0) begin
                idle(1);
                chk({nm, " dv one cycle"}, 32'(if0.data_valid), 32'd0);
                chk({nm, " fe one cycle"}, 32'(if0.frame_error), 32'd0);
                chk({nm, " register"}, 32'(reg_q), 32'(exp_reg));
                idle(vecs[v].post - 1);
            end
        end

        // bit_en low with a toggling line freezes a frame mid-way
        send_start(1, "hold");
        send_bits(8'h6B, 0, 2, 1);
        for (int i = 0; i < 20; i++) begin
            ben  = 1'b0;
            line = 1'(i % 2);
            @(posedge clock);
            #1;
            if (i == 10) chk("hold dv", 32'(if0.data_valid), 32'd0);
        end
        chk("hold busy", 32'(if0.busy), 32'd1);
        chk("hold Data_out", 32'(if0.Data_out), 32'h01);
        send_bits(8'h6B, 3, 7, 1);
        stop_check(1'b1, 1'b1, 1'b0, 8'h6B, 8'hD6, "hold");
        idle(1);
        chk("hold register", 32'(reg_q), 32'h6B);
        idle(2);

        // asynchronous reset after data bit 4 discards the partial frame
        send_start(2, "midrst");
        send_bits(8'h5A, 0, 4, 2);
        chk("midrst busy before", 32'(if0.busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst busy", 32'(if0.busy), 32'd0);
        chk("midrst busy msb", 32'(if1.busy), 32'd0);
        chk("midrst Data_out", 32'(if0.Data_out), 32'h00);
        chk("midrst dv", 32'(if0.data_valid), 32'd0);
        @(posedge clock);
        #3 reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("midrst busy after release", 32'(if0.busy), 32'd0);
        send_start(2, "ff");
        send_bits(8'hFF, 0, 7, 2);
        stop_check(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, "ff");
        idle(1);
        chk("ff register", 32'(reg_q), 32'hFF);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
